clk_div_bank: RTL and testbench

- Parametrised, fully synchronous clock-generation bank. Produces NUM_CLKS derived clock levels and matching single-cycle clock-enable pulses from one input clock.
- Each channel has a divide ratio that can be changed at run time through a valid/ready handshake.
- A PLL-style locked indication is held low for a settle period after reset or any reconfiguration.
- Sits beside the audio-codec clocking. It feeds MCLK/BCLK/LRCLK-style enables to fabric logic where a hard PLL output is unnecessary or a runtime-programmable ratio is required.

---
 rtl/clk_div_bank.sv | 142 ++++++++++++++
 tb/tb_clk_div_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CLKS programmable clock dividers driven from one reference clock.
// Each channel produces a divided clock level and a one-cycle enable pulse at each period start.
// A locked flag stays low for LOCK_CYCLES cycles after reset or any reconfiguration, after which
// all channels restart together, phase-aligned at count 0.
//
// Ports:
//   refclk     in   reference clock, all logic on its rising edge
//   rst        in   synchronous active-low reset
//   div_cfg    in   packed new ratios, channel i at [i*CNT_W +: CNT_W]
//   cfg_valid  in   div_cfg holds a new configuration
//   cfg_ready  out  bank accepts a configuration (low only while in reset)
//   outclk     out  divided clock levels, one per channel
//   outclk_en  out  one-cycle pulse at the start of each channel period
//   locked     out  channels running with the current ratios
module clk_div_bank #(
  parameter int unsigned NUM_CLKS = 4,
  parameter int unsigned CNT_W = 16,
  parameter logic [NUM_CLKS*CNT_W-1:0] DIV_INIT = {16'd20, 16'd10, 16'd2, 16'd1},
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic [NUM_CLKS*CNT_W-1:0] div_cfg,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_CLKS-1:0]       outclk,
  output logic [NUM_CLKS-1:0]       outclk_en,
  output logic                      locked
);

  localparam int unsigned SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {StRst, StSettle, StLocked} state_e;

  state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  // Packed 2-D so that element i lines up with bits [i*CNT_W +: CNT_W] of div_cfg.
  logic [NUM_CLKS-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CLKS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CLKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLKS-1:0] en_q, en_d;
  logic locked_q, locked_d;
  logic ready_q, ready_d;
  logic xfer;

  assign xfer = cfg_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StRst: begin
        state_d  = StSettle;
        settle_d = '0;
        cnt_d    = '0;
      end
      StSettle: begin
        cnt_d = '0;
        if (xfer) begin
          // A new config restarts the settle window.
          div_d    = div_cfg;
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          state_d  = StLocked;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLocked: begin
        if (xfer) begin
          div_d    = div_cfg;
          state_d  = StSettle;
          settle_d = '0;
          cnt_d    = '0;
        end else begin
          for (int i = 0; i < NUM_CLKS; i++) begin
            // >= rather than == keeps the counter bounded even if it were ever past N-1.
            if (div_q[i] < CNT_W'(2)) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] >= div_q[i] - 1'b1) begin
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      end
      default: state_d = StRst;
    endcase
  end

  // Outputs are registered images of the next count, so the first locked cycle shows count 0.
  always_comb begin
    locked_d = (state_d == StLocked);
    ready_d  = (state_d != StRst);
    outclk_d = '0;
    en_d     = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (locked_d) begin
        if (div_d[i] < CNT_W'(2)) begin
          // Ratio 0 or 1: enable every cycle, no clock level.
          en_d[i] = 1'b1;
        end else begin
          outclk_d[i] = (cnt_d[i] < (div_d[i] >> 1));
          en_d[i]     = (cnt_d[i] == '0);
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q  <= StRst;
      settle_q <= '0;
      div_q    <= DIV_INIT;
      cnt_q    <= '0;
      outclk_q <= '0;
      en_q     <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      en_q     <= en_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign outclk    = outclk_q;
  assign outclk_en = en_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: an elapsed-time model (edges since lock, modulo ratio) checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_clk_div_bank;

  localparam int NUM = 4;
  localparam int W = 16;
  localparam int LOCK = 1024;
  localparam logic [NUM*W-1:0] INIT = {16'd20, 16'd10, 16'd2, 16'd1};

  logic refclk;
  logic rst;
  logic [NUM*W-1:0] div_cfg;
  logic cfg_valid;
  logic cfg_ready;
  logic [NUM-1:0] outclk;
  logic [NUM-1:0] outclk_en;
  logic locked;

  int total = 0;
  int bad = 0;

  clk_div_bank dut (
    .refclk(refclk),
    .rst(rst),
    .div_cfg(div_cfg),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .outclk(outclk),
    .outclk_en(outclk_en),
    .locked(locked)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: lock happens LOCK edges after leaving reset or after the last accepted config.
  int  m_edge = 0;
  int  lock_at = -1;
  bit  m_live = 0;
  bit  in_rst = 0;
  bit  m_ready = 0;
  int  m_ratio[NUM];

  always @(posedge refclk) begin
    m_edge++;
    if (!rst) begin
      m_live  = 1;
      in_rst  = 1;
      m_ready = 0;
      lock_at = -1;
      for (int i = 0; i < NUM; i++) m_ratio[i] = int'(INIT[i*W +: W]);
    end else if (m_live) begin
      if (in_rst) begin
        in_rst  = 0;
        m_ready = 1;
        lock_at = m_edge + LOCK;
      end else if (cfg_valid && m_ready) begin
        for (int i = 0; i < NUM; i++) m_ratio[i] = int'(div_cfg[i*W +: W]);
        lock_at = m_edge + LOCK;
      end
    end
  end

  always @(negedge refclk) begin
    if (m_live) begin
      logic e_lock;
      logic [NUM-1:0] e_clk, e_en;
      int t;
      e_lock = (lock_at >= 0) && (m_edge >= lock_at);
      t = m_edge - lock_at;
      e_clk = '0;
      e_en = '0;
      for (int i = 0; i < NUM; i++) begin
        if (e_lock) begin
          if (m_ratio[i] < 2) e_en[i] = 1'b1;
          else begin
            e_clk[i] = ((t % m_ratio[i]) < (m_ratio[i] / 2));
            e_en[i]  = ((t % m_ratio[i]) == 0);
          end
        end
      end
      chk("model_locked", 32'(locked), 32'(e_lock));
      chk("model_ready", 32'(cfg_ready), 32'(m_ready));
      chk("model_outclk", 32'(outclk), 32'(e_clk));
      chk("model_outclk_en", 32'(outclk_en), 32'(e_en));
    end
  end

  // Counts negedges until locked rises; returns the count (bounded).
  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 3000) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic xfer(input logic [NUM*W-1:0] cfg);
    cfg_valid = 1'b1;
    div_cfg = cfg;
    @(negedge refclk);
    cfg_valid = 1'b0;
    div_cfg = {$urandom, $urandom};
  endtask

  initial begin
    int n;
    int hi;
    int ens;
    rst = 1'b0;
    cfg_valid = 1'b0;
    div_cfg = '0;

    // Reset and default ratios.
    repeat (5) @(negedge refclk);
    chk("reset_outputs", 32'({outclk, outclk_en, locked, cfg_ready}), 32'd0);
    rst = 1'b1;
    @(negedge refclk);
    chk("ready_after_release", 32'(cfg_ready), 32'd1);
    chk("unlocked_after_release", 32'(locked), 32'd0);
    wait_lock(n);
    chk("lock_delay_init", 32'(n), 32'(LOCK));
    chk("init_t0_clk", 32'(outclk), 32'b1110);
    chk("init_t0_en", 32'(outclk_en), 32'b1111);
    @(negedge refclk);
    chk("init_t1_clk", 32'(outclk), 32'b1100);
    chk("init_t1_en", 32'(outclk_en), 32'b0001);
    repeat (4) @(negedge refclk);
    chk("init_t5_clk", 32'(outclk), 32'b1000);
    chk("init_t5_en", 32'(outclk_en), 32'b0001);
    repeat (5) @(negedge refclk);
    chk("init_t10_clk", 32'(outclk), 32'b0110);
    chk("init_t10_en", 32'(outclk_en), 32'b0111);
    repeat (60) @(negedge refclk);

    // Reconfigure while locked: ch3=3, ch2=7, ch1=4, ch0=0.
    xfer({16'd3, 16'd7, 16'd4, 16'd0});
    chk("unlock_on_accept", 32'(locked), 32'd0);
    chk("clk_off_on_accept", 32'({outclk, outclk_en}), 32'd0);
    wait_lock(n);
    chk("lock_delay_cfg", 32'(n), 32'(LOCK));
    chk("cfg_t0_clk", 32'(outclk), 32'b1110);
    chk("cfg_t0_en", 32'(outclk_en), 32'b1111);
    repeat (3) @(negedge refclk);
    chk("cfg_t3_clk", 32'(outclk), 32'b1000);
    chk("cfg_t3_en", 32'(outclk_en), 32'b1001);
    repeat (60) @(negedge refclk);

    // Back-to-back reconfigs during settle.
    xfer({16'd6, 16'd6, 16'd6, 16'd6});
    repeat (600) @(negedge refclk);
    xfer({16'd5, 16'd5, 16'd5, 16'd5});
    repeat (900) @(negedge refclk);
    chk("still_settling", 32'(locked), 32'd0);
    xfer({16'd8, 16'd8, 16'd8, 16'd8});
    wait_lock(n);
    chk("lock_delay_restart", 32'(n), 32'(LOCK));
    chk("r8_t0_clk", 32'(outclk), 32'b1111);
    repeat (4) @(negedge refclk);
    chk("r8_t4_clk", 32'(outclk), 32'b0000);
    chk("r8_t4_en", 32'(outclk_en), 32'b0000);
    repeat (4) @(negedge refclk);
    chk("r8_t8_en", 32'(outclk_en), 32'b1111);
    repeat (20) @(negedge refclk);

    // Reset mid-settle; cfg_valid during reset must be ignored.
    xfer({16'd9, 16'd9, 16'd9, 16'd9});
    repeat (500) @(negedge refclk);
    rst = 1'b0;
    cfg_valid = 1'b1;
    div_cfg = {16'd2, 16'd2, 16'd2, 16'd2};
    @(negedge refclk);
    chk("midsettle_reset", 32'({outclk, outclk_en, locked, cfg_ready}), 32'd0);
    repeat (3) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    chk("ready_after_rerelease", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    wait_lock(n);
    chk("lock_delay_rereset", 32'(n), 32'(LOCK));
    chk("restored_init_clk", 32'(outclk), 32'b1110);
    chk("restored_init_en", 32'(outclk_en), 32'b1111);
    repeat (20) @(negedge refclk);

    // Maximum ratio on ch3.
    xfer({16'hFFFF, 16'd8, 16'd8, 16'd8});
    wait_lock(n);
    chk("lock_delay_max", 32'(n), 32'(LOCK));
    hi = 0;
    ens = 0;
    for (int t = 0; t < 65535; t++) begin
      hi += int'(outclk[3]);
      ens += int'(outclk_en[3]);
      @(negedge refclk);
    end
    chk("max_high_cycles", 32'(hi), 32'd32767);
    chk("max_en_per_period", 32'(ens), 32'd1);
    chk("max_wrap_en", 32'(outclk_en[3]), 32'd1);
    chk("max_wrap_clk", 32'(outclk[3]), 32'd1);
    repeat (5) @(negedge refclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
